// File: rtl/da3adc.sv
`timescale 1ns/1ps
// da3adc: serial ADC reader. Frames one conversion with chip select, drives a
// divided serial clock, shifts in FRAMEBITS bits MSB-first and presents the low
// DATABITS as a right-justified sample with a dav/ack handshake.
// Optional macro ADC_LEADZERO_CHECK_EN: flag nonzero leading bits on adcerr.
module da3adc #(
  parameter int unsigned FRAMEBITS = 16,
  parameter int unsigned DATABITS  = 12,
  parameter int unsigned DIV       = 1
) (
  input  logic                adcclk,
  input  logic                adcrst,
  input  logic                adcdav,
  output logic                davadc,
  output logic                adccs,
  output logic                adcsck,
  input  logic                adcin,
  output logic [DATABITS-1:0] adcdata,
  output logic                adcerr
);

  // Only keep the captured bits that something downstream actually looks at.
`ifdef ADC_LEADZERO_CHECK_EN
  localparam int unsigned SW = FRAMEBITS;
`else
  localparam int unsigned SW = DATABITS;
`endif

  localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
  localparam logic [6:0] BITS_LAST = 7'(FRAMEBITS);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StDone} state_t;

  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [6:0]            bits_q, bits_d;
  logic [SW-2:0]         shreg_q, shreg_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  dav_q, dav_d;
  logic [DATABITS-1:0]   data_q, data_d;
  logic [SW-1:0]         shifted;
  logic [6:0]            bits_inc;
  logic                  phase_end;

  // Word as it stands once the current adcin bit is shifted in.
  assign shifted   = {shreg_q, adcin};
  assign bits_inc  = bits_q + 7'd1;
  assign phase_end = (div_q == DIV_LAST);

`ifdef ADC_LEADZERO_CHECK_EN
  logic err_q, err_d;
  assign adcerr = err_q;
`else
  assign adcerr = 1'b0;
`endif

  // Next-state logic: abort on dropped request beats every state action.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    shreg_d = shreg_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    dav_d   = dav_q;
    data_d  = data_q;
`ifdef ADC_LEADZERO_CHECK_EN
    err_d   = err_q;
`endif
    if (!adcdav) begin
      state_d = StIdle;
      cs_d    = 1'b1;
      sck_d   = 1'b0;
      dav_d   = 1'b0;
      div_d   = '0;
      bits_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!dav_q) begin
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            div_d   = '0;
            bits_d  = '0;
            shreg_d = '0;
            state_d = StSetup;
          end
        end
        StSetup, StLow: begin
          if (phase_end) begin
            div_d   = '0;
            sck_d   = 1'b1;
            state_d = StHigh;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        StHigh: begin
          if (phase_end) begin
            // Sample on the falling sck edge, before the ADC moves SDATA.
            div_d   = '0;
            sck_d   = 1'b0;
            shreg_d = shifted[SW-2:0];
            bits_d  = bits_inc;
            if (bits_inc == BITS_LAST) begin
              cs_d    = 1'b1;
              dav_d   = 1'b1;
              data_d  = shifted[DATABITS-1:0];
`ifdef ADC_LEADZERO_CHECK_EN
              err_d   = |shifted[SW-1:DATABITS];
`endif
              state_d = StDone;
            end else begin
              state_d = StLow;
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge adcclk) begin
    if (adcrst) begin
      state_q <= StIdle;
      div_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      dav_q   <= 1'b0;
      data_q  <= '0;
`ifdef ADC_LEADZERO_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      dav_q   <= dav_d;
      data_q  <= data_d;
`ifdef ADC_LEADZERO_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign davadc  = dav_q;
  assign adccs   = cs_q;
  assign adcsck  = sck_q;
  assign adcdata = data_q;

endmodule

// File: tb/tb_da3adc.sv
`timescale 1ns/1ps
// Testbench for da3adc: two instances (DIV=1 and DIV=4), each with a behavioural
// ADC that presents its frame word MSB-first, and a scoreboard of expected samples.
module tb_da3adc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dav = 1'b0;
  logic        dav4 = 1'b0;
  logic        ack, cs, sck, err;
  logic        ack4, cs4, sck4, err4;
  logic        sdi = 1'b0;
  logic        sdi4 = 1'b0;
  logic [11:0] data, data4;

  always #5 clk = ~clk;

  da3adc #(.FRAMEBITS(16), .DATABITS(12), .DIV(1)) dut (
    .adcclk(clk), .adcrst(rst), .adcdav(dav), .davadc(ack), .adccs(cs),
    .adcsck(sck), .adcin(sdi), .adcdata(data), .adcerr(err)
  );

  da3adc #(.FRAMEBITS(16), .DATABITS(12), .DIV(4)) dut4 (
    .adcclk(clk), .adcrst(rst), .adcdav(dav4), .davadc(ack4), .adccs(cs4),
    .adcsck(sck4), .adcin(sdi4), .adcdata(data4), .adcerr(err4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {adcerr, adcdata} for a frame word.
  function automatic logic [12:0] exp_word(input logic [15:0] w);
`ifdef ADC_LEADZERO_CHECK_EN
    return {|w[15:12], w[11:0]};
`else
    return {1'b0, w[11:0]};
`endif
  endfunction

  // ADC models: first bit on cs fall, next bit after each sck fall.
  logic [15:0] word = '0, word4 = '0, sh = '0, sh4 = '0;
  logic        pcs = 1'b1, psck = 1'b0, pcs4 = 1'b1, psck4 = 1'b0;
  int          rises = 0, rises4 = 0, viol = 0, viol4 = 0, highs4 = 0;

  always @(posedge clk) begin
    #1;
    if (pcs && !cs) sh = word;
    else if (psck && !sck && !cs) sh = sh << 1;
    sdi = sh[15];
    if (!psck && sck) rises++;
    if (sck && cs) viol++;
    pcs = cs;
    psck = sck;
  end

  always @(posedge clk) begin
    #1;
    if (pcs4 && !cs4) sh4 = word4;
    else if (psck4 && !sck4 && !cs4) sh4 = sh4 << 1;
    sdi4 = sh4[15];
    if (!psck4 && sck4) rises4++;
    if (sck4) highs4++;
    if (sck4 && cs4) viol4++;
    pcs4 = cs4;
    psck4 = sck4;
  end

  logic [12:0] sb[$];
  logic [12:0] sb4[$];

  // Run one DIV=1 frame; adcdav is left high on return.
  task automatic run_frame(input logic [15:0] w, input string tag);
    int          base;
    int          n;
    bit          got;
    logic [12:0] e;
    word = w;
    sb.push_back(exp_word(w));
    base = rises;
    dav = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_cs_fall"}, 32'(cs), 32'd0);
      if (ack) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(n - 1), 32'd32);
    e = sb.pop_front();
    if (got) begin
      check({tag, "_data"}, 32'(data), 32'(e[11:0]));
      check({tag, "_err"}, 32'(err), 32'(e[12]));
    end else begin
      check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    end
    check({tag, "_sck_rises"}, 32'(rises - base), 32'd16);
  endtask

  initial begin
    int          base;
    int          hb;
    int          n;
    int          first;
    bit          got;
    logic [12:0] e;

    repeat (2) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load a nonzero sample so the mid-frame reset has something to clear.
    run_frame(16'h0ABC, "pre");
    dav = 1'b0;
    @(negedge clk);

    // Reset at edge 9 of a fresh frame, held for two clocks.
    word = 16'h0555;
    dav = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs", 32'(cs), 32'd1);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dav = 1'b0;
    @(negedge clk);

    run_frame(16'h0ABC, "t2");

    // Hold the request well past the ack: no re-trigger, no extra pulses.
    base = rises;
    repeat (50) @(negedge clk);
    check("hold_sck_rises", 32'(rises - base), 32'd0);
    check("hold_cs", 32'(cs), 32'd1);
    check("hold_ack", 32'(ack), 32'd1);
    dav = 1'b0;
    @(negedge clk);
    check("drop_ack", 32'(ack), 32'd0);
    check("drop_cs", 32'(cs), 32'd1);
    check("drop_data_kept", 32'(data), 32'h0ABC);

    // Abort at edge 10.
    word = 16'h0555;
    dav = 1'b1;
    repeat (10) @(negedge clk);
    dav = 1'b0;
    @(negedge clk);
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_data", 32'(data), 32'h0ABC);
    @(negedge clk);
    run_frame(16'h0DEF, "t3");
    dav = 1'b0;
    @(negedge clk);

    run_frame(16'h8ABC, "t5a");
    dav = 1'b0;
    @(negedge clk);
    e = exp_word(16'h8ABC);
    check("t5a_err_held", 32'(err), 32'(e[12]));
    run_frame(16'h0001, "t5b");
    dav = 1'b0;
    @(negedge clk);

    // DIV=4 instance.
    word4 = 16'h0123;
    sb4.push_back(exp_word(16'h0123));
    base = rises4;
    hb = highs4;
    dav4 = 1'b1;
    got = 1'b0;
    n = 0;
    first = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (sck4 && first == 0) first = n;
      if (ack4) got = 1'b1;
    end
    check("div4_first_rise", 32'(first - 1), 32'd4);
    check("div4_latency", 32'(n - 1), 32'd128);
    check("div4_sck_high_cycles", 32'(highs4 - hb), 32'd64);
    check("div4_sck_rises", 32'(rises4 - base), 32'd16);
    e = sb4.pop_front();
    check("div4_data", 32'(data4), 32'(e[11:0]));
    check("div4_err", 32'(err4), 32'(e[12]));
    dav4 = 1'b0;
    @(negedge clk);
    check("div4_drop_ack", 32'(ack4), 32'd0);

    check("sck_while_cs_high", 32'(viol), 32'd0);
    check("sck_while_cs_high_div4", 32'(viol4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
